inst_mem_fetch: RTL and testbench

Parametrised, writable, byte-addressed instruction memory with a valid/ready fetch interface and one-cycle registered read. It replaces the fixed 64-byte combinational instruction ROM in front of the RISC-V fetch stage. It adds:
- a word-write load port for program loading;
- misalignment and out-of-range error reporting;
- back-pressure handling;
- a saturating fetch counter.

---
 rtl/inst_mem_fetch.sv | 89 ++++++++
 tb/tb_inst_mem_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_fetch.sv
// Writable byte-addressed instruction memory with a valid/ready fetch port,
// one-cycle registered read, error reporting and a saturating fetch counter.
module inst_mem_fetch #(
   parameter int          ADDR_W      = 64,
   parameter int          DEPTH_BYTES = 256,
   parameter logic [31:0] NOP_INSTR   = 32'h00000013,
   parameter int          CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_instr,
   output logic              rsp_err,
   output logic [1:0]        rsp_err_code,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [3:0]        wr_be,
   input  logic [31:0]       wr_data,
   output logic [CNT_W-1:0]  fetch_cnt
);

   localparam int                BA_W      = $clog2(DEPTH_BYTES);
   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH_BYTES - 4);

   logic [7:0] mem [DEPTH_BYTES];

   logic            accept_p0;
   logic [1:0]      err_code_p0;
   logic [31:0]     rd_data_p0;
   logic [BA_W-3:0] rd_word_p0;
   logic [BA_W-3:0] wr_word_p0;
   logic            wr_ok_p0;

   // Error code is {out_of_range, misaligned}; range is checked at full width.
   function automatic logic [1:0] fetch_err(input logic [ADDR_W-1:0] a);
      return {a > LAST_WORD, a[1:0] != 2'b00};
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
   endfunction

   assign req_ready   = !rsp_valid || rsp_ready;
   assign accept_p0   = req_valid && req_ready;
   assign err_code_p0 = fetch_err(req_addr);
   assign rd_word_p0  = req_addr[BA_W-1:2];
   assign wr_word_p0  = wr_addr[BA_W-1:2];
   assign wr_ok_p0    = wr_en && !(wr_addr > LAST_WORD);

   always_comb begin
      rd_data_p0 = {mem[{rd_word_p0, 2'd3}], mem[{rd_word_p0, 2'd2}],
                    mem[{rd_word_p0, 2'd1}], mem[{rd_word_p0, 2'd0}]};
   end

   // Load port; the read above sees pre-edge contents, giving read-before-write.
   always_ff @(posedge clk) begin
      if (wr_ok_p0) begin
         for (int k = 0; k < 4; k++) begin
            if (wr_be[k]) begin
               mem[{wr_word_p0, 2'(k)}] <= wr_data[8*k +: 8];
            end
         end
      end
   end

   // ---- response stage ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid    <= 1'b0;
         rsp_instr    <= '0;
         rsp_err      <= 1'b0;
         rsp_err_code <= 2'b00;
         fetch_cnt    <= '0;
      end else if (accept_p0) begin
         rsp_valid    <= 1'b1;
         rsp_instr    <= (err_code_p0 != 2'b00) ? NOP_INSTR : rd_data_p0;
         rsp_err      <= (err_code_p0 != 2'b00);
         rsp_err_code <= err_code_p0;
         fetch_cnt    <= sat_inc(fetch_cnt);
      end else if (rsp_ready) begin
         rsp_valid    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Randomized scoreboard bench for inst_mem_fetch against a byte-array reference model.
module tb_inst_mem_fetch;

   typedef struct packed {
      logic [31:0] instr;
      logic        err;
      logic [1:0]  code;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic        rsp_err;
   logic [1:0]  rsp_err_code;
   logic        wr_en;
   logic [63:0] wr_addr;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic [3:0]  fetch_cnt;

   int   total = 0;
   int   bad   = 0;
   int   mcnt  = 0;
   bit   mon_on = 1'b0;
   rsp_t sb[$];
   logic [7:0] rm [256];

   inst_mem_fetch #(.ADDR_W(64), .DEPTH_BYTES(256), .NOP_INSTR(32'h00000013), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
      .rsp_err(rsp_err), .rsp_err_code(rsp_err_code),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
      .fetch_cnt(fetch_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic rsp_t ref_fetch(input logic [63:0] a);
      rsp_t r;
      logic mis, oor;
      int   b;
      mis     = (a % 4) != 0;
      oor     = a > 64'd252;
      r.code  = {oor, mis};
      r.err   = mis || oor;
      r.instr = 32'h00000013;
      if (!r.err) begin
         b = int'(a);
         r.instr = {rm[b+3], rm[b+2], rm[b+1], rm[b]};
      end
      return r;
   endfunction

   task automatic ref_write(input logic [63:0] a, input logic [3:0] be, input logic [31:0] d);
      int base;
      if (a <= 64'd252) begin
         base = int'(a) / 4 * 4;
         for (int k = 0; k < 4; k++)
            if (be[k]) rm[base+k] = d[8*k +: 8];
      end
   endtask

   function automatic logic [63:0] rand_addr();
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 5)      return 64'($urandom_range(0, 63)) * 4;
      else if (sel == 6) return 64'($urandom_range(0, 255));
      else if (sel == 7) return 64'($urandom_range(248, 259));
      else if (sel == 8) return {32'($urandom), 32'($urandom)};
      else               return 64'h1_0000_0000 + 64'($urandom_range(0, 255));
   endfunction

   // One clock cycle: drive at negedge, update the model just after posedge.
   task automatic cyc(input bit rv, input logic [63:0] ra, input bit we, input logic [63:0] wa,
                      input logic [3:0] be, input logic [31:0] wd, input bit rr);
      bit   acc;
      rsp_t e;
      @(negedge clk);
      req_valid = rv; req_addr = ra; wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
      rsp_ready = rr;
      #1;
      acc = rv && (sb.size() == 0 || rr);
      e   = ref_fetch(ra);
      @(posedge clk);
      #1;
      if (acc) begin
         sb.push_back(e);
         if (mcnt < 15) mcnt++;
      end
      if (we) ref_write(wa, be, wd);
   endtask

   task automatic idle(input bit rr);
      cyc(1'b0, 64'd0, 1'b0, 64'd0, 4'h0, 32'd0, rr);
   endtask

   task automatic fetch(input logic [63:0] a, input bit rr);
      cyc(1'b1, a, 1'b0, 64'd0, 4'h0, 32'd0, rr);
   endtask

   // Monitor: checks handshake, counter and the response head between edges.
   initial begin
      rsp_t h;
      forever begin
         @(negedge clk);
         #2;
         if (mon_on && rst) begin
            chk("rsp_valid", rsp_valid, sb.size() != 0);
            chk("req_ready", req_ready, sb.size() == 0 || rsp_ready);
            chk("fetch_cnt", fetch_cnt, mcnt);
            if (rsp_valid && sb.size() != 0) begin
               h = sb[0];
               chk("rsp_instr", rsp_instr, h.instr);
               chk("rsp_err", rsp_err, h.err);
               chk("rsp_err_code", rsp_err_code, h.code);
               if (rsp_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", rsp_valid, 0);
      chk("reset_instr", rsp_instr, 0);
      chk("reset_err", rsp_err, 0);
      chk("reset_code", rsp_err_code, 0);
      chk("reset_cnt", fetch_cnt, 0);
      chk("reset_ready", req_ready, 1);
      #1 rst = 1'b1;
      mon_on = 1'b1;

      for (int w = 0; w < 64; w++) begin
         d = (w == 0) ? 32'h00000433 : (w == 3) ? 32'h11223344 : 32'($urandom);
         cyc(1'b0, 64'd0, 1'b1, 64'(w * 4), 4'hf, d, 1'b1);
      end

      fetch(64'd0, 1'b1);
      chk("load_fetch_instr", rsp_instr, 32'h00000433);
      chk("load_fetch_cnt", fetch_cnt, 1);
      idle(1'b1);

      fetch(64'd2, 1'b1);
      fetch(64'd256, 1'b1);
      fetch(64'd254, 1'b1);
      fetch(64'd252, 1'b1);
      fetch(64'h1_0000_0000, 1'b1);
      idle(1'b1);

      fetch(64'd4, 1'b1);
      repeat (3) fetch(64'd8, 1'b0);
      fetch(64'd8, 1'b1);
      idle(1'b1);

      cyc(1'b1, 64'd12, 1'b1, 64'd12, 4'b0010, 32'hAABBCCDD, 1'b1);
      chk("rbw_old", rsp_instr, 32'h11223344);
      fetch(64'd12, 1'b1);
      chk("rbw_new", rsp_instr, 32'h1122CC44);
      idle(1'b1);

      for (int i = 0; i < 20; i++) fetch(64'($urandom_range(0, 63)) * 4, 1'b1);
      chk("sat_cnt", fetch_cnt, 15);
      idle(1'b1);

      for (int i = 0; i < 300; i++) begin
         logic [63:0] wa;
         wa = ($urandom_range(0, 4) == 0) ? rand_addr() : 64'($urandom_range(0, 255));
         cyc($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 3) == 0, wa,
             4'($urandom), $urandom, $urandom_range(0, 3) != 0);
      end
      idle(1'b1);

      fetch(64'd0, 1'b0);
      idle(1'b0);
      #2 rst = 1'b0;
      #1;
      chk("arst_valid", rsp_valid, 0);
      chk("arst_cnt", fetch_cnt, 0);
      chk("arst_instr", rsp_instr, 0);
      sb.delete();
      mcnt = 0;
      #1 rst = 1'b1;
      fetch(64'd0, 1'b1);
      idle(1'b1);
      idle(1'b1);
      chk("drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
